smvm_issue_ctrl: RTL and testbench

Issue scheduler in front of the SMVM ALU tree.
- Accepts a stream of nonzero matrix entries (value, column index, IPV row-end flag) over a valid/ready handshake.
- Packs them into K-wide bundles and issues each bundle to the ALU L1 stage with its own valid/ready handshake.
- Pads the final partial bundle with zeros, waits out the ALU pipeline drain, and counts completed rows.

---
 rtl/smvm_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_smvm_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smvm_issue_ctrl.sv
// Issue scheduler for the SMVM ALU tree: packs nonzero entries into K-wide bundles,
// issues them under valid/ready, pads the final partial bundle, drains, and counts rows.
module smvm_issue_ctrl #(
    parameter int K     = 4,
    parameter int VW    = 8,
    parameter int CW    = 7,
    parameter int DRAIN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            nz_valid,
    output logic            nz_ready,
    input  logic [VW-1:0]   nz_val,
    input  logic [CW-1:0]   nz_col,
    input  logic            nz_ipv,
    input  logic            nz_last,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [K*VW-1:0] iss_val,
    output logic [K*CW-1:0] iss_col,
    output logic [K-1:0]    iss_ipv,
    output logic [K-1:0]    iss_mask,
    output logic            busy,
    output logic            done,
    output logic [7:0]      row_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the sender holds its payload stable while valid is high and ready is low.

    localparam int CNTW = (K > 1) ? $clog2(K) : 1;
    localparam int TW   = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      row_cnt_q, row_cnt_d;
    logic [VW-1:0]   slot_val_q [K];
    logic [VW-1:0]   slot_val_d [K];
    logic [CW-1:0]   slot_col_q [K];
    logic [CW-1:0]   slot_col_d [K];
    logic [K-1:0]    slot_ipv_q, slot_ipv_d;
    logic [K-1:0]    mask_q, mask_d;

    logic [8:0]      ipv_pop;
    logic [8:0]      row_sum;
    logic [7:0]      row_sat;

    always_comb begin
        ipv_pop = '0;
        for (int i = 0; i < K; i++) begin
            ipv_pop = ipv_pop + 9'(slot_ipv_q[i]);
        end
        row_sum = {1'b0, row_cnt_q} + ipv_pop;
        row_sat = row_sum[8] ? 8'hff : row_sum[7:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        timer_d    = timer_q;
        row_cnt_d  = row_cnt_q;
        slot_val_d = slot_val_q;
        slot_col_d = slot_col_q;
        slot_ipv_d = slot_ipv_q;
        mask_d     = mask_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FILL;
                    row_cnt_d = '0;
                end
            end
            S_FILL: begin
                if (nz_valid) begin
                    slot_val_d[cnt_q] = nz_val;
                    slot_col_d[cnt_q] = nz_col;
                    slot_ipv_d[cnt_q] = nz_ipv;
                    mask_d[cnt_q]     = 1'b1;
                    cnt_d             = cnt_q + 1'b1;
                    // Row ends do not close a bundle; only a full bundle or the matrix end does.
                    if ((cnt_q == CNTW'(K - 1)) || nz_last) begin
                        state_d = S_ISSUE;
                        last_d  = nz_last;
                    end
                end
            end
            S_ISSUE: begin
                if (iss_ready) begin
                    row_cnt_d = row_sat;
                    cnt_d     = '0;
                    mask_d    = '0;
                    slot_ipv_d = '0;
                    for (int i = 0; i < K; i++) begin
                        slot_val_d[i] = '0;
                        slot_col_d[i] = '0;
                    end
                    if (last_q) begin
                        state_d = S_DRAIN;
                        timer_d = TW'(DRAIN - 1);
                        last_d  = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_DRAIN: begin
                if (timer_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            timer_q    <= '0;
            row_cnt_q  <= '0;
            slot_ipv_q <= '0;
            mask_q     <= '0;
            for (int i = 0; i < K; i++) begin
                slot_val_q[i] <= '0;
                slot_col_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            row_cnt_q  <= row_cnt_d;
            slot_ipv_q <= slot_ipv_d;
            mask_q     <= mask_d;
            for (int i = 0; i < K; i++) begin
                slot_val_q[i] <= slot_val_d[i];
                slot_col_q[i] <= slot_col_d[i];
            end
        end
    end

    // Slot 0 is presented in the most significant position of every bundle field.
    always_comb begin
        iss_val  = '0;
        iss_col  = '0;
        iss_ipv  = '0;
        iss_mask = '0;
        for (int i = 0; i < K; i++) begin
            iss_val[(K-1-i)*VW +: VW] = slot_val_q[i];
            iss_col[(K-1-i)*CW +: CW] = slot_col_q[i];
            iss_ipv[K-1-i]            = slot_ipv_q[i];
            iss_mask[K-1-i]           = mask_q[i];
        end
    end

    assign nz_ready  = (state_q == S_FILL);
    assign iss_valid = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_smvm_issue_ctrl.sv
// Directed bench for smvm_issue_ctrl: a bundle model feeds an expected queue that is
// checked at every issue handshake, plus timing, backpressure and reset checks.
module tb_smvm_issue_ctrl;

  localparam int K     = 4;
  localparam int VW    = 8;
  localparam int CW    = 7;
  localparam int DRAIN = 4;
  localparam int W     = K * (VW + CW + 2);

  logic            clk;
  logic            rst;
  logic            start;
  logic            nz_valid;
  logic            nz_ready;
  logic [VW-1:0]   nz_val;
  logic [CW-1:0]   nz_col;
  logic            nz_ipv;
  logic            nz_last;
  logic            iss_valid;
  logic            iss_ready;
  logic [K*VW-1:0] iss_val;
  logic [K*CW-1:0] iss_col;
  logic [K-1:0]    iss_ipv;
  logic [K-1:0]    iss_mask;
  logic            busy;
  logic            done;
  logic [7:0]      row_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;

  logic [W-1:0] exp_q[$];

  logic [K*VW-1:0] m_val;
  logic [K*CW-1:0] m_col;
  logic [K-1:0]    m_ipv;
  logic [K-1:0]    m_mask;
  int              m_cnt;
  int              m_rows;

  smvm_issue_ctrl #(.K(K), .VW(VW), .CW(CW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .nz_valid(nz_valid), .nz_ready(nz_ready), .nz_val(nz_val), .nz_col(nz_col),
    .nz_ipv(nz_ipv), .nz_last(nz_last),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_val(iss_val), .iss_col(iss_col),
    .iss_ipv(iss_ipv), .iss_mask(iss_mask),
    .busy(busy), .done(done), .row_cnt(row_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bundle model
  task automatic model_clear();
    m_val  = '0;
    m_col  = '0;
    m_ipv  = '0;
    m_mask = '0;
    m_cnt  = 0;
  endtask

  task automatic model_add(input logic [VW-1:0] v, input logic [CW-1:0] c,
                           input logic ipv, input logic last);
    m_val[(K-1-m_cnt)*VW +: VW] = v;
    m_col[(K-1-m_cnt)*CW +: CW] = c;
    m_ipv[K-1-m_cnt]            = ipv;
    m_mask[K-1-m_cnt]           = 1'b1;
    if (ipv && m_rows < 255) m_rows++;
    m_cnt++;
    if (m_cnt == K || last) begin
      exp_q.push_back({m_val, m_col, m_ipv, m_mask});
      model_clear();
    end
  endtask

  // drivers
  task automatic start_job();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_rows = 0;
    model_clear();
  endtask

  task automatic push(input logic [VW-1:0] v, input logic [CW-1:0] c,
                      input logic ipv, input logic last);
    int n;
    nz_val   = v;
    nz_col   = c;
    nz_ipv   = ipv;
    nz_last  = last;
    nz_valid = 1'b1;
    n = 0;
    while (!nz_ready && n < 100) begin
      tick();
      n++;
    end
    if (!nz_ready) check("nz_ready_timeout", {79'd0, nz_ready}, 80'd1);
    tick();
    nz_valid = 1'b0;
    nz_last  = 1'b0;
    model_add(v, c, ipv, last);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {79'd0, done}, 80'd1);
    if (done) check("done_latency", 80'(cyc), 80'(last_hs + DRAIN));
    check("row_cnt_final", {72'd0, row_cnt}, 80'(m_rows));
    check("exp_q_drained", 80'(exp_q.size()), 80'd0);
    @(negedge clk);
    check("done_one_cycle", {79'd0, done}, 80'd0);
    check("busy_after_done", {79'd0, busy}, 80'd0);
    tick();
  endtask

  // scoreboard: compare each bundle on the cycle its handshake completes
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      last_hs = cyc + 1;
      check("bundle_expected", {79'd0, exp_q.size() != 0}, 80'd1);
      if (exp_q.size() != 0) begin
        check("bundle", 80'({iss_val, iss_col, iss_ipv, iss_mask}), 80'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [W-1:0] snap;
    rst = 1'b1; start = 1'b0; nz_valid = 1'b0; nz_val = '0; nz_col = '0;
    nz_ipv = 1'b0; nz_last = 1'b0; iss_ready = 1'b1;
    m_rows = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_nz_ready", {79'd0, nz_ready}, 80'd0);
    check("rst_iss_valid", {79'd0, iss_valid}, 80'd0);
    check("rst_iss_fields", 80'({iss_val, iss_col, iss_ipv, iss_mask}), 80'd0);
    check("rst_busy_done", {78'd0, busy, done}, 80'd0);
    check("rst_row_cnt", {72'd0, row_cnt}, 80'd0);
    rst = 1'b0;
    tick();

    // two full bundles, row ends on entries 3 and 7
    start_job();
    check("fill_after_start", {79'd0, nz_ready}, 80'd1);
    for (int i = 0; i < 8; i++) begin
      push(VW'($urandom_range(0, 255)), CW'($urandom_range(0, 127)), (i == 3 || i == 7), (i == 7));
    end
    wait_done();

    // six entries, padded second bundle
    start_job();
    for (int i = 1; i <= 6; i++) begin
      push(VW'(i), CW'(9 + i), 1'b0, (i == 6));
    end
    wait_done();

    // backpressure on the first bundle
    iss_ready = 1'b0;
    start_job();
    for (int i = 0; i < 4; i++) begin
      push(VW'($urandom_range(0, 255)), CW'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'b0);
    end
    check("bp_valid_rise", {79'd0, iss_valid}, 80'd1);
    snap = {iss_val, iss_col, iss_ipv, iss_mask};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", 80'({iss_val, iss_col, iss_ipv, iss_mask}), 80'(snap));
      check("bp_nz_ready", {79'd0, nz_ready}, 80'd0);
      check("bp_valid_held", {79'd0, iss_valid}, 80'd1);
    end
    @(posedge clk);
    #1;
    iss_ready = 1'b1;
    tick();
    check("bp_fill_resumes", {79'd0, nz_ready}, 80'd1);
    check("bp_valid_drop", {79'd0, iss_valid}, 80'd0);
    push(8'h5a, 7'd3, 1'b1, 1'b0);
    push(8'ha5, 7'd4, 1'b1, 1'b1);
    wait_done();

    // single entry job
    start_job();
    push(8'h81, 7'd127, 1'b1, 1'b1);
    wait_done();

    // asynchronous reset while the second bundle waits in ISSUE
    start_job();
    for (int i = 0; i < 4; i++) push(VW'(i + 20), CW'(i + 40), (i == 3), 1'b0);
    push(8'h11, 7'd1, 1'b0, 1'b0);
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(VW'(i + 30), CW'(i + 2), 1'b0, 1'b0);
    check("pre_rst_valid", {79'd0, iss_valid}, 80'd1);
    check("pre_rst_row_cnt", {72'd0, row_cnt}, 80'(m_rows));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {79'd0, iss_valid}, 80'd0);
    check("async_rst_busy", {79'd0, busy}, 80'd0);
    check("async_rst_row_cnt", {72'd0, row_cnt}, 80'd0);
    check("async_rst_fields", 80'({iss_val, iss_col, iss_ipv, iss_mask}), 80'd0);
    exp_q.delete();
    model_clear();
    tick();
    rst = 1'b0;
    iss_ready = 1'b1;
    tick();
    start_job();
    for (int i = 0; i < 4; i++) begin
      push(VW'($urandom_range(0, 255)), CW'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), (i == 3));
    end
    wait_done();

    // start pulses in FILL and DRAIN are ignored
    start_job();
    push(8'h01, 7'd5, 1'b0, 1'b0);
    push(8'h02, 7'd6, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_fill_ready", {79'd0, nz_ready}, 80'd1);
    check("start_in_fill_rows", {72'd0, row_cnt}, 80'd0);
    push(8'h03, 7'd7, 1'b0, 1'b0);
    push(8'h04, 7'd8, 1'b1, 1'b0);
    push(8'h05, 7'd9, 1'b0, 1'b0);
    push(8'h06, 7'd10, 1'b1, 1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_drain_busy", {79'd0, busy}, 80'd1);
    check("start_in_drain_ready", {79'd0, nz_ready}, 80'd0);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
